map_mem_arbiter: RTL and testbench
==================================

Name: map_mem_arbiter

Overview:
- Sequences and shares the 16x8 single-port map memory between three sources:
  - the Nios host Avalon-MM slave port;
  - the MTL render engine tile-read port;
  - a built-in clear/fill sequencer.
- Sits between the SOPC interconnect and the RAM. It is the only block that drives the RAM address, chipselect and write signals.
- The RAM has a registered address and unregistered output, so readdata is valid one cycle after the address is presented.

Parameters:
- ADDR_W, 4, map memory address width.
- DATA_W, 8, map memory data width.
- DEPTH, 16, number of words; the clear sweep covers addresses 0..DEPTH-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- host_address  in  ADDR_W  host word address.
- host_chipselect  in  1  host select.
- host_read  in  1  host read request; qualified by chipselect.
- host_write  in  1  host write request; qualified by chipselect.
- host_writedata  in  DATA_W  host write data.
- host_readdata  out  DATA_W  host read data; valid when waitrequest=0 on a read.
- host_waitrequest  out  1  Avalon waitrequest.
- rd_req  in  1  render read request; a level, held until rd_ack.
- rd_addr  in  ADDR_W  render address; stable while rd_req=1.
- rd_ack  out  1  one-cycle pulse; rd_data is valid in that cycle.
- rd_data  out  DATA_W  render read data; holds its value until the next rd_ack.
- clr_start  in  1  pulse; fill the whole map with clr_value.
- clr_value  in  DATA_W  fill value; sampled in the clr_start cycle.
- clr_busy  out  1  clear is pending or in progress.
- mem_address  out  ADDR_W  RAM address.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write enable.
- mem_writedata  out  DATA_W  RAM write data.
- mem_readdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, last_grant=RENDER, clr_pending=0, clear counter=0.
  - All outputs are 0 except host_waitrequest, which is 1.
  - Any in-flight access is dropped. The host must reissue after reset.
- State machine: IDLE, H_WR, H_ADDR, H_DATA, H_DONE, R_ADDR, R_DATA, R_DONE, CLEAR.
- host_waitrequest = 0 only in H_WR and H_DONE; it is 1 in every other state. rd_ack = 1 only in R_DONE.
- host_req = host_chipselect & (host_read | host_write). If read and write are both set, the access is treated as a write.
- Arbitration in IDLE, evaluated every cycle:
  - clr_pending has top priority and goes to CLEAR.
  - If only host_req or only rd_req is set, that source is granted.
  - If both are set, the source that is not last_grant wins (round-robin); last_grant is updated on each grant.
  - Host is granted first after reset.
- Host write path, IDLE->H_WR->IDLE:
  - In H_WR: mem_chipselect=1, mem_write=1, mem_address=host_address, mem_writedata=host_writedata, waitrequest=0.
  - The write completes one cycle after the grant.
- Host read path, IDLE->H_ADDR->H_DATA->H_DONE->IDLE:
  - H_ADDR drives mem_address=host_address with chipselect=1.
  - H_DATA registers mem_readdata into host_readdata.
  - H_DONE asserts waitrequest=0.
  - Latency: read asserted at cycle T in IDLE gives waitrequest=0 and valid data at T+3.
- Render read path, IDLE->R_ADDR->R_DATA->R_DONE->IDLE:
  - Same timing as the host read; rd_data is registered in R_DATA.
  - rd_ack pulses at T+3. If rd_req is still high after the ack, that is a new request.
- Clear:
  - clr_start in any state with clr_busy=0 sets clr_pending and latches clr_value. clr_busy goes to 1 the next cycle.
  - clr_start while clr_busy=1 is ignored.
  - The clear waits for the current access to finish, then enters CLEAR at the next IDLE.
  - In CLEAR: write the latched value to address = counter, counter increments by 1 each cycle, DEPTH cycles total.
  - After the write to address DEPTH-1: counter wraps to 0, clr_pending=0, clr_busy=0 the next cycle, return to IDLE.
  - Host and render requests stall during CLEAR and are served afterwards under normal arbitration.
- An access in progress is never pre-empted; the arbiter only switches in IDLE.
- If a master withdraws its request mid-access, the access still completes and the result is discarded.
- Outside active states, mem_chipselect=0 and mem_write=0.

Test Plan:
- Host write 0x5A to addr 3, then host read addr 3: write waitrequest=0 at T+1; read waitrequest=0 at T+3 with host_readdata=0x5A.
- Host read and rd_req asserted in the same IDLE cycle after reset: host is served first (done T+3), then render (rd_ack at T+7). Repeat with both held: grants alternate host, render, host.
- clr_start with clr_value=0xFF while a render read is in R_ADDR: the render read finishes, then 16 consecutive writes to addr 0..15 occur. clr_busy falls one cycle after the addr-15 write. All 16 read back 0xFF.
- Second clr_start during CLEAR with value 0x00: ignored; the map stays 0xFF. A host read issued during CLEAR stalls (waitrequest=1) until CLEAR ends.
- reset_n pulsed low while in H_DATA: all outputs return to reset values immediately, state=IDLE. A reissued read returns correct data at T+3.
- Host chipselect=1 with read=write=1, data 0x11 at addr 15: treated as a write; addr 15 reads back 0x11.

Source files
------------

// File: rtl/map_mem_arbiter.sv
// Shares the single-port map RAM between the host Avalon-MM slave, the render
// tile-read port and a built-in clear/fill sequencer.
module map_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] host_address,
  input  logic              host_chipselect,
  input  logic              host_read,
  input  logic              host_write,
  input  logic [DATA_W-1:0] host_writedata,
  output logic [DATA_W-1:0] host_readdata,
  output logic              host_waitrequest,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [3:0] {
    IDLE, H_WR, H_ADDR, H_DATA, H_DONE, R_ADDR, R_DATA, R_DONE, CLEAR
  } state_t;

  typedef enum logic {GRANT_HOST, GRANT_RENDER} grant_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_t              state;
  grant_t              last_grant;
  logic                clr_pending;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   clr_val;

  logic host_req;
  logic host_wins;

  assign host_req  = host_chipselect & (host_read | host_write);
  // Round-robin only matters when both request; host goes first out of reset.
  assign host_wins = host_req & (~rd_req | (last_grant == GRANT_RENDER));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= GRANT_RENDER;
      clr_pending   <= 1'b0;
      clr_cnt       <= '0;
      clr_val       <= '0;
      host_readdata <= '0;
      rd_data       <= '0;
    end else begin
      if (clr_start && !clr_pending) begin
        clr_pending <= 1'b1;
        clr_val     <= clr_value;
      end

      case (state)
        IDLE: begin
          if (clr_pending) begin
            state <= CLEAR;
          end else if (host_wins) begin
            state      <= host_write ? H_WR : H_ADDR;
            last_grant <= GRANT_HOST;
          end else if (rd_req) begin
            state      <= R_ADDR;
            last_grant <= GRANT_RENDER;
          end
        end
        H_WR:   state <= IDLE;
        H_ADDR: state <= H_DATA;
        H_DATA: begin
          host_readdata <= mem_readdata;
          state         <= H_DONE;
        end
        H_DONE: state <= IDLE;
        R_ADDR: state <= R_DATA;
        R_DATA: begin
          rd_data <= mem_readdata;
          state   <= R_DONE;
        end
        R_DONE: state <= IDLE;
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            clr_cnt     <= '0;
            clr_pending <= 1'b0;
            state       <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host_waitrequest = ~((state == H_WR) || (state == H_DONE));
  assign rd_ack           = (state == R_DONE);
  assign clr_busy         = clr_pending;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    case (state)
      H_WR: begin
        mem_address    = host_address;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_writedata  = host_writedata;
      end
      H_ADDR: begin
        mem_address    = host_address;
        mem_chipselect = 1'b1;
      end
      R_ADDR: begin
        mem_address    = rd_addr;
        mem_chipselect = 1'b1;
      end
      CLEAR: begin
        mem_address    = clr_cnt;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_writedata  = clr_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Directed bench for map_mem_arbiter with a behavioural registered-address RAM.
module tb_map_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] host_address;
  logic       host_chipselect, host_read, host_write;
  logic [7:0] host_writedata, host_readdata;
  logic       host_waitrequest;
  logic       rd_req, rd_ack;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       clr_start, clr_busy;
  logic [7:0] clr_value;
  logic [3:0] mem_address;
  logic       mem_chipselect, mem_write;
  logic [7:0] mem_writedata, mem_readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  map_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_address(host_address), .host_chipselect(host_chipselect),
    .host_read(host_read), .host_write(host_write),
    .host_writedata(host_writedata), .host_readdata(host_readdata),
    .host_waitrequest(host_waitrequest),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata)
  );

  // RAM: address registered on chipselect, output read combinationally.
  logic [7:0] ram [16];
  logic [3:0] ram_addr_q = '0;
  initial for (int i = 0; i < 16; i++) ram[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      ram_addr_q <= mem_address;
      if (mem_write) ram[mem_address] <= mem_writedata;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_idle();
    host_chipselect = 1'b0;
    host_read       = 1'b0;
    host_write      = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic host_write_op(input logic [3:0] a, input logic [7:0] d);
    host_address = a; host_writedata = d;
    host_chipselect = 1'b1; host_write = 1'b1; host_read = 1'b0;
    tick();
    total++;
    if (host_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_address !== a ||
        mem_writedata !== d) begin
      bad++;
      $display("FAIL host_write a=%0d: wr=%b we=%b maddr=%0d wd=%h, need wr=0 we=1 maddr=%0d wd=%h",
               a, host_waitrequest, mem_write, mem_address, mem_writedata, a, d);
    end
    host_idle();
    tick();
  endtask

  task automatic host_read_op(input logic [3:0] a, input logic [7:0] exp);
    logic early;
    host_address = a;
    host_chipselect = 1'b1; host_read = 1'b1; host_write = 1'b0;
    tick();
    early = ~host_waitrequest;
    tick();
    early |= ~host_waitrequest;
    tick();
    total++;
    if (early || host_waitrequest !== 1'b0 || host_readdata !== exp) begin
      bad++;
      $display("FAIL host_read a=%0d: early=%b wr@T+3=%b data=%h, need early=0 wr=0 data=%h",
               a, early, host_waitrequest, host_readdata, exp);
    end
    host_idle();
    tick();
  endtask

  task automatic test_reset();
    host_idle();
    host_address = 4'd9; host_writedata = 8'hC3;
    rd_req = 1'b0; rd_addr = 4'd6; clr_start = 1'b0; clr_value = 8'h00;
    reset_n = 1'b0;
    #3;
    total++;
    if ({host_waitrequest, rd_ack, clr_busy, mem_chipselect, mem_write} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags: got %b need 10000",
               {host_waitrequest, rd_ack, clr_busy, mem_chipselect, mem_write});
    end
    total++;
    if ({mem_address, mem_writedata, host_readdata, rd_data} !== 28'h0) begin
      bad++;
      $display("FAIL reset_buses: got %h need 0",
               {mem_address, mem_writedata, host_readdata, rd_data});
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    host_write_op(4'd3, 8'h5A);
    host_read_op(4'd3, 8'h5A);
  endtask

  task automatic test_arbitration();
    int host_t [2];
    int rend_t;
    int nh;
    do_reset();
    // Both request in the same IDLE cycle: host first, render after.
    host_address = 4'd3; host_chipselect = 1'b1; host_read = 1'b1;
    rd_addr = 4'd3; rd_req = 1'b1;
    nh = 0; rend_t = -1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (!host_waitrequest && nh == 0) begin host_t[0] = c; nh++; host_idle(); end
      if (rd_ack && rend_t < 0) begin
        rend_t = c; rd_req = 1'b0;
        total++;
        if (rd_data !== 8'h5A) begin
          bad++;
          $display("FAIL arb_rd_data: got %h need 5a", rd_data);
        end
      end
    end
    total++;
    if (nh != 1 || host_t[0] != 3 || rend_t != 7) begin
      bad++;
      $display("FAIL arb_order: host_done=%0d rd_ack=%0d need 3 and 7", host_t[0], rend_t);
    end
    host_idle(); rd_req = 1'b0;
    tick();
    // Both held continuously: host, render, host.
    host_chipselect = 1'b1; host_read = 1'b1; rd_req = 1'b1;
    nh = 0; rend_t = -1; host_t[0] = -1; host_t[1] = -1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (!host_waitrequest && nh < 2) begin host_t[nh] = c; nh++; end
      if (rd_ack && rend_t < 0) rend_t = c;
    end
    host_idle(); rd_req = 1'b0;
    total++;
    if (host_t[0] != 3 || rend_t != 7 || host_t[1] != 11) begin
      bad++;
      $display("FAIL arb_alternate: host=%0d,%0d render=%0d need 3,11 and 7",
               host_t[0], host_t[1], rend_t);
    end
    tick();
    tick();
  endtask

  task automatic test_clear();
    logic early_wr;
    rd_addr = 4'd2; rd_req = 1'b1;
    early_wr = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 1) begin clr_start = 1'b1; clr_value = 8'hFF; end
      if (c == 2) begin
        clr_start = 1'b0; clr_value = 8'h00;
        total++;
        if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_busy_rise: got %b need 1", clr_busy); end
      end
      if (c == 3) begin
        total++;
        if (rd_ack !== 1'b1 || rd_data !== 8'h00) begin
          bad++;
          $display("FAIL clr_render_first: ack=%b data=%h need 1 00", rd_ack, rd_data);
        end
        rd_req = 1'b0;
      end
      if (c >= 5 && c <= 20) begin
        total++;
        if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 ||
            mem_address !== 4'(c - 5) || mem_writedata !== 8'hFF) begin
          bad++;
          $display("FAIL clr_sweep c=%0d: cs=%b we=%b addr=%0d wd=%h need 1 1 %0d ff",
                   c, mem_chipselect, mem_write, mem_address, mem_writedata, c - 5);
        end
      end
      if (c == 8) clr_start = 1'b1;
      if (c == 9) clr_start = 1'b0;
      if (c == 10) begin host_address = 4'd7; host_chipselect = 1'b1; host_read = 1'b1; end
      if (c >= 10 && c <= 23 && !host_waitrequest) early_wr = 1'b1;
      if (c == 20) begin
        total++;
        if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_busy_last: got %b need 1", clr_busy); end
      end
      if (c == 21) begin
        total++;
        if (clr_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_fall: got %b need 0", clr_busy); end
      end
      if (c == 24) begin
        total++;
        if (early_wr || host_waitrequest !== 1'b0 || host_readdata !== 8'hFF) begin
          bad++;
          $display("FAIL clr_host_stall: early=%b wr=%b data=%h need 0 0 ff",
                   early_wr, host_waitrequest, host_readdata);
        end
        host_idle();
      end
      if (c == 26) begin
        total++;
        if (clr_busy !== 1'b0) begin bad++; $display("FAIL clr_second_ignored: busy=%b need 0", clr_busy); end
      end
    end
    for (int a = 0; a < 16; a++) host_read_op(4'(a), 8'hFF);
  endtask

  task automatic test_reset_mid_read();
    host_address = 4'd3; host_chipselect = 1'b1; host_read = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    total++;
    if ({host_waitrequest, rd_ack, clr_busy, mem_chipselect, mem_write} !== 5'b10000 ||
        host_readdata !== 8'h00 || mem_address !== 4'h0) begin
      bad++;
      $display("FAIL reset_mid_read: flags=%b data=%h addr=%0d need 10000 00 0",
               {host_waitrequest, rd_ack, clr_busy, mem_chipselect, mem_write},
               host_readdata, mem_address);
    end
    host_idle();
    tick();
    reset_n = 1'b1;
    tick();
    host_read_op(4'd3, 8'hFF);
  endtask

  task automatic test_read_write_both();
    host_address = 4'd15; host_writedata = 8'h11;
    host_chipselect = 1'b1; host_read = 1'b1; host_write = 1'b1;
    tick();
    total++;
    if (host_waitrequest !== 1'b0 || mem_write !== 1'b1) begin
      bad++;
      $display("FAIL rw_as_write: wr=%b we=%b need 0 1", host_waitrequest, mem_write);
    end
    host_idle();
    tick();
    host_read_op(4'd15, 8'h11);
    host_read_op(4'd14, 8'hFF);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_clear();
    test_reset_mid_read();
    test_read_write_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
